// File: rtl/bubble_sort_ctrl_if.sv
// Stream bundle between the bubble-sort sequencer and its neighbours.
//   s_valid/s_ready/s_data          : input byte stream into the sequencer
//   m_valid/m_ready/m_data/m_last   : sorted byte stream out of the sequencer
// master: the environment side (drives s_valid, s_data, m_ready)
// slave : the sequencer side   (drives s_ready, m_valid, m_data, m_last)
interface bubble_sort_ctrl_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/bubble_sort_ctrl.sv
// Stream-side sequencer for the bubble_sorting_top pipeline.
// Collects INPUT_NUM bytes from the input stream into the sorter's packed vector,
// fires one sort_cks launch pulse, waits for sort_done (bounded by MAX_WAIT),
// captures the sorted vector and drains it byte-by-byte on the output stream.
//
// Ports:
//   clk, rst     : single clock, synchronous active-high reset
//   bus          : bubble_sort_ctrl_if.slave (s_* input stream, m_* output stream)
//   sort_din     : to sorter data_in, element k at [8k+7:8k]
//   sort_cks     : to sorter cks_in, one-cycle launch pulse
//   sort_dout    : from sorter data_out
//   sort_done    : from sorter final cks_out stage
//   clr_err      : clears timeout_err
//   busy         : low only in LOAD with no bytes collected
//   timeout_err  : sticky, set when WAIT gives up on sort_done
//
// Build option: define SORT_DESC_EN to drain elements N-1 down to 0.
//
// state  | meaning
// LOAD   | accept input bytes into sort_din
// LAUNCH | one cycle, sort_cks high
// WAIT   | waiting for sort_done, bounded by MAX_WAIT cycles
// DRAIN  | presenting captured result on the output stream
module bubble_sort_ctrl #(
    parameter int INPUT_NUM = 8,
    parameter int MAX_WAIT  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    bubble_sort_ctrl_if.slave      bus,
    output logic [8*INPUT_NUM-1:0] sort_din,
    output logic                   sort_cks,
    input  logic [8*INPUT_NUM-1:0] sort_dout,
    input  logic                   sort_done,
    input  logic                   clr_err,
    output logic                   busy,
    output logic                   timeout_err
);
    localparam int CW = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST_IDX  = CW'(INPUT_NUM - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {LOAD, LAUNCH, WAIT, DRAIN} state_t;

    state_t state, state_next;

    logic [CW-1:0]          load_cnt;
    logic [CW-1:0]          drain_idx;
    logic [CW-1:0]          drain_sel;
    logic [WW-1:0]          wait_cnt;
    logic [8*INPUT_NUM-1:0] result;
    logic                   m_valid_q;
    logic                   s_fire;
    logic                   m_fire;
    logic                   load_last;
    logic                   wait_expired;

    // s_ready is combinational so it drops while rst is held, before the reset edge.
    assign bus.s_ready  = (state == LOAD) && !rst;
    assign s_fire       = bus.s_valid && bus.s_ready;
    assign m_fire       = m_valid_q && bus.m_ready;
    assign load_last    = (load_cnt == LAST_IDX);
    // Done has priority over expiry in the final WAIT cycle.
    assign wait_expired = (state == WAIT) && !sort_done && (wait_cnt == WAIT_LAST);

`ifdef SORT_DESC_EN
    assign drain_sel = LAST_IDX - drain_idx;
`else
    assign drain_sel = drain_idx;
`endif

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = result[8*drain_sel +: 8];
    assign bus.m_last  = m_valid_q && (drain_idx == LAST_IDX);
    assign busy        = !((state == LOAD) && (load_cnt == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (s_fire && load_last) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT: begin
                if (sort_done)                   state_next = DRAIN;
                else if (wait_cnt == WAIT_LAST)  state_next = LOAD;
            end
            DRAIN:   if (m_fire && bus.m_last) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt    <= '0;
            drain_idx   <= '0;
            wait_cnt    <= '0;
            sort_din    <= '0;
            result      <= '0;
            sort_cks    <= 1'b0;
            m_valid_q   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Both registered off the next state so they line up exactly with LAUNCH/DRAIN.
            sort_cks  <= (state_next == LAUNCH);
            m_valid_q <= (state_next == DRAIN);

            if (s_fire) begin
                sort_din[8*load_cnt +: 8] <= bus.s_data;
                load_cnt <= load_last ? '0 : load_cnt + CW'(1);
            end

            if (state == WAIT) begin
                if (sort_done || (wait_cnt == WAIT_LAST)) wait_cnt <= '0;
                else                                      wait_cnt <= wait_cnt + WW'(1);
                if (sort_done) result <= sort_dout;
            end

            if (m_fire) begin
                drain_idx <= (drain_idx == LAST_IDX) ? '0 : drain_idx + CW'(1);
            end

            if (wait_expired)  timeout_err <= 1'b1;
            else if (clr_err)  timeout_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Scoreboard bench for bubble_sort_ctrl with a behavioural sorter model.
module tb_bubble_sort_ctrl;
    localparam int N        = 8;
    localparam int MAX_WAIT = 64;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [8*N-1:0] sort_din;
    logic [8*N-1:0] sort_dout;
    logic           sort_cks;
    logic           sort_done;
    logic           clr_err;
    logic           busy;
    logic           timeout_err;

    bubble_sort_ctrl_if bus();

    bubble_sort_ctrl #(.INPUT_NUM(N), .MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .sort_din    (sort_din),
        .sort_cks    (sort_cks),
        .sort_dout   (sort_dout),
        .sort_done   (sort_done),
        .clr_err     (clr_err),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    beat_t exp_q[$];
    int    mr_mode   = 0;
    int    sort_lat  = 4;
    bit    no_done   = 1'b0;
    int    stray_req = 0;
    int    cks_cnt   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [8*N-1:0] sort_vec(input logic [8*N-1:0] v);
        byte unsigned   q[$];
        logic [8*N-1:0] r;
        for (int k = 0; k < N; k++) q.push_back(v[8*k +: 8]);
        q.sort();
        r = '0;
        for (int k = 0; k < N; k++) r[8*k +: 8] = q[k];
        return r;
    endfunction

    // Downstream ready pattern: 0 always ready, 1 repeating 1,0,0,1, 2 random.
    initial begin
        int ph;
        ph = 0;
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (mr_mode)
                0: bus.m_ready = 1'b1;
                1: begin
                    bus.m_ready = (ph == 0) || (ph == 3);
                    ph = (ph + 1) % 4;
                end
                default: bus.m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Sorter model: done arrives in WAIT cycle sort_lat after the launch pulse.
    initial begin
        int             stray_ack;
        bit             pend;
        int             cnt;
        logic [8*N-1:0] pend_vec;
        stray_ack = 0;
        pend      = 1'b0;
        cnt       = 0;
        pend_vec  = '0;
        sort_done = 1'b0;
        sort_dout = '0;
        forever begin
            @(posedge clk); #1;
            sort_done = 1'b0;
            if (stray_req != stray_ack) begin
                stray_ack++;
                sort_done = 1'b1;
                sort_dout = {$urandom(), $urandom()};
            end else if (pend) begin
                if (cnt == 0) begin
                    sort_done = 1'b1;
                    sort_dout = pend_vec;
                    pend      = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (rst) pend = 1'b0;
            if (sort_cks && !no_done) begin
                pend     = 1'b1;
                cnt      = sort_lat;
                pend_vec = sort_vec(sort_din);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (sort_cks) cks_cnt++;
    end

    // Output monitor: pops the scoreboard on every handshake, checks hold during stalls.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        beat_t      e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && bus.m_valid) check("m_data_hold", bus.m_data, prev_data);
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got %0h expected no beat", bus.m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", bus.m_data, e.data);
                        check("m_last", bus.m_last, e.last);
                    end
                end
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_data  = bus.m_data;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_bytes(input byte unsigned vals[$], input int gap_max);
        logic acc;
        int   guard;
        foreach (vals[i]) begin
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            bus.s_valid = 1'b1;
            bus.s_data  = vals[i];
            guard = 0;
            do begin
                @(negedge clk);
                acc = bus.s_ready;
                @(posedge clk); #1;
                guard++;
            end while (!acc && guard < 300);
            if (!acc) check("s_accept_timeout", 1'b0, 1'b1);
            bus.s_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("post_drain_m_valid", bus.m_valid, 1'b0);
        check("post_drain_s_ready", bus.s_ready, 1'b1);
        check("post_drain_busy", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic run_batch(input byte unsigned vals[$], input int gap_max, input int lat,
                             input bit stray_drain);
        byte unsigned   srt[$];
        logic [8*N-1:0] pv;
        beat_t          b;
        int             guard;
        sort_lat = lat;
        srt = vals;
        srt.sort();
`ifdef SORT_DESC_EN
        srt.reverse();
`endif
        foreach (srt[i]) begin
            b.data = srt[i];
            b.last = (i == N - 1);
            exp_q.push_back(b);
        end
        pv = '0;
        foreach (vals[i]) pv[8*i +: 8] = vals[i];
        send_bytes(vals, gap_max);
        @(negedge clk);
        check("sort_cks_launch", sort_cks, 1'b1);
        check("sort_din", sort_din, pv);
        @(negedge clk);
        check("sort_cks_single", sort_cks, 1'b0);
        if (stray_drain) begin
            guard = 0;
            while (!bus.m_valid && guard < 200) begin @(negedge clk); guard++; end
            check("drain_reached", bus.m_valid, 1'b1);
            @(posedge clk); #1;
            stray_req++;
        end
        wait_drain();
    endtask

    task automatic run_timeout(input byte unsigned vals[$], input bit clr_hold);
        no_done = 1'b1;
        if (clr_hold) clr_err = 1'b1;
        send_bytes(vals, 0);
        @(negedge clk);
        check("to_sort_cks", sort_cks, 1'b1);
        repeat (MAX_WAIT) @(negedge clk);
        check("to_err_before", timeout_err, 1'b0);
        check("to_s_ready_wait", bus.s_ready, 1'b0);
        @(negedge clk);
        check("to_err_set", timeout_err, 1'b1);
        check("to_s_ready_load", bus.s_ready, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_m_valid", bus.m_valid, 1'b0);
        if (clr_hold) begin
            @(negedge clk);
            check("to_err_clr_held", timeout_err, 1'b0);
            @(posedge clk); #1;
            clr_err = 1'b0;
        end else begin
            repeat (3) @(negedge clk);
            check("to_err_sticky", timeout_err, 1'b1);
            @(posedge clk); #1;
            clr_err = 1'b1;
            @(posedge clk); #1;
            clr_err = 1'b0;
            @(negedge clk);
            check("to_err_cleared", timeout_err, 1'b0);
            @(posedge clk); #1;
        end
        no_done = 1'b0;
    endtask

    initial begin
        byte unsigned base[$];
        byte unsigned part[$];
        byte unsigned rv[$];
        int           c0;

        base = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd7, 8'd2, 8'd6, 8'd4};
        rst         = 1'b1;
        clr_err     = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", bus.s_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_s_ready", bus.s_ready, 1'b1);
        check("reset_m_valid", bus.m_valid, 1'b0);
        check("reset_m_last", bus.m_last, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_sort_cks", sort_cks, 1'b0);
        check("reset_timeout_err", timeout_err, 1'b0);
        check("reset_sort_din", sort_din, 64'd0);
        check("reset_m_data", bus.m_data, 8'd0);
        @(posedge clk); #1;

        mr_mode = 0;
        run_batch(base, 0, 4, 1'b0);

        mr_mode = 1;
        run_batch(base, 0, 2, 1'b0);

        mr_mode = 0;
        run_timeout(base, 1'b0);
        run_timeout(base, 1'b1);

        part = base[0:3];
        send_bytes(part, 0);
        @(negedge clk);
        check("partial_busy", busy, 1'b1);
        c0 = cks_cnt;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_s_ready", bus.s_ready, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_busy", busy, 1'b0);
        check("after_rst_s_ready", bus.s_ready, 1'b1);
        @(posedge clk); #1;
        stray_req++;
        repeat (4) @(negedge clk);
        check("stray_load_m_valid", bus.m_valid, 1'b0);
        check("stray_load_busy", busy, 1'b0);
        check("stray_load_s_ready", bus.s_ready, 1'b1);
        @(posedge clk); #1;
        check("no_partial_launch", 32'(cks_cnt), 32'(c0));
        mr_mode = 1;
        run_batch(base, 1, 5, 1'b1);

        mr_mode = 0;
        rv.delete();
        for (int k = 0; k < N; k++) rv.push_back(8'($urandom_range(0, 255)));
        run_batch(rv, 0, MAX_WAIT - 1, 1'b0);
        check("late_done_no_err", timeout_err, 1'b0);

        mr_mode = 2;
        for (int t = 0; t < 12; t++) begin
            rv.delete();
            for (int k = 0; k < N; k++) rv.push_back(8'($urandom_range(0, 255)));
            run_batch(rv, 3, $urandom_range(0, 20), 1'b0);
        end
        check("final_no_err", timeout_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
